// File: rtl/lcd_arb_pkg.sv
// ----------------------------------------------------------------------------
// lcd_arb_pkg
// Shared definitions for the LCD image-ROM arbiter:
//   - default geometry of the image ROM (address/data width, word count,
//     burst length width)
//   - arbiter FSM state encoding
//   - response source tags used to route ROM data back to its consumer
// No ports (package).
// ----------------------------------------------------------------------------
package lcd_arb_pkg;

  localparam int ARB_ADDR_W = 17;
  localparam int ARB_DATA_W = 16;
  localparam int ARB_DEPTH  = 76800;
  localparam int ARB_LEN_W  = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic SRC_DISP = 1'b0;
  localparam logic SRC_AUX  = 1'b1;

endpackage

// File: rtl/aux_burst_ctr.sv
// ----------------------------------------------------------------------------
// aux_burst_ctr
// Address pointer and remaining-word counter for the auxiliary burst reader.
// The pointer wraps from DEPTH-1 back to 0 so bursts can run past the end of
// the frame buffer.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   load     : capture base/len (start of a burst)
//   base     : burst start address
//   len      : burst word count
//   adv      : one read was issued this cycle; advance pointer, decrement count
//   ptr      : current read address
//   rem      : words still to be issued
//   last     : the next issue is the final one of the burst
// ----------------------------------------------------------------------------
module aux_burst_ctr
  import lcd_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LEN_W  = ARB_LEN_W,
  parameter int DEPTH  = ARB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic              adv,
  output logic [ADDR_W-1:0] ptr,
  output logic [LEN_W-1:0]  rem,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      rem <= '0;
    end else if (load) begin
      ptr <= base;
      rem <= len;
    end else if (adv) begin
      ptr <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
      rem <= rem - 1'b1;
    end
  end

  assign last = (rem == LEN_W'(1));

endmodule

// File: rtl/lcd_rom_arbiter.sv
// ----------------------------------------------------------------------------
// lcd_rom_arbiter
// Time-shares the single-port image ROM (1-cycle registered read) between the
// real-time LCD pixel fetch (always wins) and an auxiliary burst reader that
// only reads in cycles the display leaves free. Drives the ROM address and
// routes the returned word to the requester that issued the read; data and
// valid appear two cycles after the request.
// Optional feature macro: ARB_STATS_EN (adds stat_stall / stat_words).
// Ports:
//   CLK, RST              : pixel clock, synchronous active-high reset
//   disp_en, disp_addr    : display read request
//   disp_data, disp_valid : display read response
//   aux_start, aux_base, aux_len : burst request (accepted only when idle)
//   aux_busy              : burst in progress (issuing or draining)
//   aux_data, aux_valid   : auxiliary read response
//   aux_done              : one-cycle completion pulse
//   rom_addr, rom_q       : ROM address out / registered ROM data in
//   stat_stall, stat_words: (ARB_STATS_EN only) stall and word counters
// ----------------------------------------------------------------------------
module lcd_rom_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int DEPTH  = ARB_DEPTH,
  parameter int LEN_W  = ARB_LEN_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              disp_en,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              aux_start,
  input  logic [ADDR_W-1:0] aux_base,
  input  logic [LEN_W-1:0]  aux_len,
  output logic              aux_busy,
  output logic [DATA_W-1:0] aux_data,
  output logic              aux_valid,
  output logic              aux_done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_stall,
  output logic [15:0]       stat_words
`endif
);

  arb_state_t        state, state_nxt;
  logic              issue;
  logic              accept;
  logic              load;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  rem;
  logic              last;
  logic              vld_p0;
  logic              tag_p0;

  assign accept = (state == IDLE) && aux_start;
  assign load   = accept && (aux_len != '0);

  aux_burst_ctr #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W),
    .DEPTH (DEPTH)
  ) u_ctr (
    .clk (CLK),
    .rst (RST),
    .load(load),
    .base(aux_base),
    .len (aux_len),
    .adv (issue),
    .ptr (ptr),
    .rem (rem),
    .last(last)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (aux_len != '0) ? BURST : DONE;
      end
      BURST: begin
        if (issue && last) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The display owns the ROM whenever it asks; aux issues only fill gaps.
  always_comb begin
    issue    = (state == BURST) && !disp_en;
    aux_busy = (state == BURST) || (state == DRAIN);
    aux_done = (state == DONE);
    rom_addr = issue ? ptr : disp_addr;
  end

  // Stage p0: remember who owns the read now in flight inside the ROM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p0 <= 1'b0;
      tag_p0 <= SRC_DISP;
    end else begin
      vld_p0 <= disp_en || issue;
      tag_p0 <= disp_en ? SRC_DISP : SRC_AUX;
    end
  end

  // Stage p1: capture rom_q into the owner's output register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      disp_valid <= 1'b0;
      aux_valid  <= 1'b0;
      disp_data  <= '0;
      aux_data   <= '0;
    end else begin
      disp_valid <= vld_p0 && (tag_p0 == SRC_DISP);
      aux_valid  <= vld_p0 && (tag_p0 == SRC_AUX);
      if (vld_p0 && (tag_p0 == SRC_DISP)) disp_data <= rom_q;
      if (vld_p0 && (tag_p0 == SRC_AUX))  aux_data  <= rom_q;
    end
  end

`ifdef ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Words are counted as they are delivered, so the final count is visible
  // in the same cycle as aux_done.
  always_ff @(posedge CLK) begin
    if (RST || accept) begin
      stat_stall <= '0;
      stat_words <= '0;
    end else begin
      if ((state == BURST) && disp_en) stat_stall <= sat_inc(stat_stall);
      if (vld_p0 && (tag_p0 == SRC_AUX)) stat_words <= stat_words + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_rom_arbiter.sv
module tb_lcd_rom_arbiter;

  logic        clk = 1'b0;
  logic        RST;
  logic        disp_en;
  logic [16:0] disp_addr;
  logic [15:0] disp_data;
  logic        disp_valid;
  logic        aux_start;
  logic [16:0] aux_base;
  logic [16:0] aux_len;
  logic        aux_busy;
  logic [15:0] aux_data;
  logic        aux_valid;
  logic        aux_done;
  logic [16:0] rom_addr;
  logic [15:0] rom_q;
`ifdef ARB_STATS_EN
  logic [15:0] stat_stall;
  logic [15:0] stat_words;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_rom_arbiter dut (
    .CLK       (clk),
    .RST       (RST),
    .disp_en   (disp_en),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .aux_start (aux_start),
    .aux_base  (aux_base),
    .aux_len   (aux_len),
    .aux_busy  (aux_busy),
    .aux_data  (aux_data),
    .aux_valid (aux_valid),
    .aux_done  (aux_done),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q)
`ifdef ARB_STATS_EN
    ,
    .stat_stall(stat_stall),
    .stat_words(stat_words)
`endif
  );

  // ROM contents: word = low 16 address bits + 0x1000, one-cycle registered read
  function automatic logic [15:0] word(input logic [16:0] a);
    return a[15:0] + 16'h1000;
  endfunction

  always_ff @(posedge clk) rom_q <= word(rom_addr);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [16:0] wexp [4];
    int nav;
    wexp = '{17'd76798, 17'd76799, 17'd0, 17'd1};

    RST = 1'b1; disp_en = 1'b0; disp_addr = '0;
    aux_start = 1'b0; aux_base = '0; aux_len = '0;
    cyc(); cyc();
    RST = 1'b0; #2;
    chk("rst_busy", aux_busy, 0);
    chk("rst_aux_valid", aux_valid, 0);
    chk("rst_aux_done", aux_done, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_disp_data", disp_data, 0);
    chk("rst_aux_data", aux_data, 0);
    cyc();

    // Burst base=100 len=4 with the display idle
    aux_base = 17'd100; aux_len = 17'd4; aux_start = 1'b1; #2;
    chk("t1_busy_c0", aux_busy, 0);
    cyc(); aux_start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      #2;
      if (c <= 4) chk("t1_rom_addr", rom_addr, 99 + c);
      chk("t1_busy", aux_busy, (c <= 5));
      chk("t1_aux_valid", aux_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk("t1_aux_data", aux_data, word(17'(97 + c)));
      chk("t1_aux_done", aux_done, (c == 6));
      cyc();
    end

    // Burst base=10 len=6, display busy 2 of every 3 cycles; start coincides with disp_en
    aux_base = 17'd10; aux_len = 17'd6; aux_start = 1'b1;
    disp_en = 1'b1; disp_addr = 17'd499;
    cyc(); aux_start = 1'b0;
    nav = 0;
    for (int j = 0; j < 22; j++) begin
      disp_en = (j < 18) && (j % 3 != 2);
      disp_addr = 17'(500 + j);
      #2;
      if (disp_en) chk("t2_rom_disp", rom_addr, 500 + j);
      else if (j < 18) chk("t2_rom_aux", rom_addr, 10 + j / 3);
      if (j == 1) begin
        chk("t2_dv_first", disp_valid, 1);
        chk("t2_dd_first", disp_data, word(17'd499));
      end else if (j >= 2 && j - 2 < 18 && (j - 2) % 3 != 2) begin
        chk("t2_dv", disp_valid, 1);
        chk("t2_dd", disp_data, word(17'(500 + j - 2)));
      end else begin
        chk("t2_dv_idle", disp_valid, 0);
      end
      if (j >= 4 && j - 2 < 18 && (j - 2) % 3 == 2) begin
        chk("t2_av", aux_valid, 1);
        chk("t2_ad", aux_data, word(17'(10 + (j - 2) / 3)));
      end else begin
        chk("t2_av_idle", aux_valid, 0);
      end
      chk("t2_done", aux_done, (j == 19));
      chk("t2_busy", aux_busy, (j <= 18));
      if (aux_valid) nav++;
      cyc();
    end
    chk("t2_aux_count", nav, 6);
    disp_en = 1'b0;

    // Wrap at the end of the frame buffer
    aux_base = 17'd76798; aux_len = 17'd4; aux_start = 1'b1;
    cyc(); aux_start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #2;
      if (c <= 4) chk("t3_rom_wrap", rom_addr, wexp[c - 1]);
      if (c == 6) begin
        chk("t3_last_data", aux_data, word(17'd1));
        chk("t3_done", aux_done, 1);
      end
      cyc();
    end

    // Zero-length burst
    disp_addr = '0;
    aux_base = 17'd0; aux_len = 17'd0; aux_start = 1'b1;
    cyc(); aux_start = 1'b0; #2;
    chk("t4_len0_done", aux_done, 1);
    chk("t4_len0_busy", aux_busy, 0);
    chk("t4_len0_valid", aux_valid, 0);
    cyc(); #2;
    chk("t4_len0_done_end", aux_done, 0);
    chk("t4_len0_valid_end", aux_valid, 0);
    cyc();

    // Second aux_start during a burst is ignored
    aux_base = 17'd200; aux_len = 17'd3; aux_start = 1'b1;
    cyc();
    aux_base = 17'd300; aux_len = 17'd9; aux_start = 1'b1; #2;
    chk("t4_rom_c1", rom_addr, 200);
    cyc(); aux_start = 1'b0; #2;
    chk("t4_rom_c2", rom_addr, 201);
    cyc(); #2;
    chk("t4_rom_c3", rom_addr, 202);
    cyc(); #2;
    chk("t4_rom_drain", rom_addr, 0);
    chk("t4_busy_drain", aux_busy, 1);
    cyc(); #2;
    chk("t4_done", aux_done, 1);
    chk("t4_last_data", aux_data, word(17'd202));
    cyc(); #2;
    chk("t4_idle_after", aux_busy, 0);
    cyc();

    // Reset on the 3rd cycle of a len=8 burst
    aux_base = 17'd1000; aux_len = 17'd8; aux_start = 1'b1;
    cyc(); aux_start = 1'b0;
    cyc(); cyc();
    RST = 1'b1; #2;
    chk("t5_pre_rst_valid", aux_valid, 1);
    cyc(); RST = 1'b0; #2;
    chk("t5_busy", aux_busy, 0);
    chk("t5_aux_valid", aux_valid, 0);
    chk("t5_aux_done", aux_done, 0);
    chk("t5_disp_valid", disp_valid, 0);
    chk("t5_aux_data", aux_data, 0);
    chk("t5_disp_data", disp_data, 0);
    for (int c = 0; c < 8; c++) begin
      cyc(); #2;
      chk("t5_quiet_valid", aux_valid, 0);
      chk("t5_quiet_done", aux_done, 0);
    end
    cyc();
    aux_base = 17'd5; aux_len = 17'd2; aux_start = 1'b1;
    cyc(); aux_start = 1'b0; #2;
    chk("t5_new_rom0", rom_addr, 5);
    cyc(); #2;
    chk("t5_new_rom1", rom_addr, 6);
    cyc(); #2;
    chk("t5_new_av0", aux_valid, 1);
    chk("t5_new_ad0", aux_data, word(17'd5));
    cyc(); #2;
    chk("t5_new_ad1", aux_data, word(17'd6));
    chk("t5_new_done", aux_done, 1);
    cyc();

`ifdef ARB_STATS_EN
    // len=5 with 7 stalled BURST cycles
    aux_base = 17'd20; aux_len = 17'd5; aux_start = 1'b1;
    cyc(); aux_start = 1'b0;
    for (int j = 0; j < 14; j++) begin
      disp_en = (j < 7);
      disp_addr = 17'(700 + j);
      #2;
      if (j == 13) begin
        chk("st_done", aux_done, 1);
        chk("st_words", stat_words, 5);
        chk("st_stall", stat_stall, 7);
      end
      cyc();
    end
    disp_en = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
